// File: rtl/serv_wb_timer.sv
// serv_wb_timer: Wishbone classic machine timer (mtime/mtimecmp) with a
// programmable prescaler, driving the SERV core's timer interrupt.
//
// Build option: define SERV_WB_TIMER_MTIME64_EN for 64-bit mtime/mtimecmp
// with read/write HI registers. Without it the timer is 32 bits wide and
// the HI registers read 0 and ignore writes.
//
// Register map (adr[4:2]):
//   0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI,
//   4 CTRL {DIV at [8 +: PRESCALE_W], EN at [0]}, 5-7 unmapped (read 0).
// PRESCALE_W must be at most 24 so DIV fits in the 32-bit CTRL word.

module serv_wb_timer #(
   parameter int unsigned PRESCALE_W = 8,
   parameter bit          RESET_EN   = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [4:0]  i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_timer_irq
);

`ifdef SERV_WB_TIMER_MTIME64_EN
   localparam int unsigned TIME_W = 64;
`else
   localparam int unsigned TIME_W = 32;
`endif

   localparam logic [2:0] REG_MTIME_LO    = 3'd0;
   localparam logic [2:0] REG_MTIME_HI    = 3'd1;
   localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] REG_CTRL        = 3'd4;

   // Replace the byte lanes of old_val selected by lanes with new_val.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (lanes[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   // State
   logic                  ack_q;
   logic [31:0]           rdt_q, rdt_d;
   logic                  irq_q, irq_d;
   logic [TIME_W-1:0]     mtime_q, mtime_d;
   logic [TIME_W-1:0]     mtimecmp_q, mtimecmp_d;
   logic                  en_q, en_d;
   logic [PRESCALE_W-1:0] div_q, div_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;

   // Decode
   logic        access;
   logic        wr;
   logic [2:0]  reg_sel;
   logic        wr_mtime_lo, wr_mtime_hi;
   logic        wr_cmp_lo, wr_cmp_hi;
   logic        wr_ctrl;
   logic        tick;

   // 32-bit views of the timer registers for the bus
   logic [31:0] mtime_lo, mtime_hi, cmp_lo, cmp_hi;
   logic [31:0] ctrl_rd, ctrl_new;
   logic        unused_bits;

   // An access is serviced on the edge that raises ack.
   assign access  = i_wb_cyc & ~ack_q;
   // A write with no byte lanes enabled is not a write at all.
   assign wr      = access & i_wb_we & (|i_wb_sel);
   assign reg_sel = i_wb_adr[4:2];

   assign wr_mtime_lo = wr & (reg_sel == REG_MTIME_LO);
   assign wr_cmp_lo   = wr & (reg_sel == REG_MTIMECMP_LO);
   assign wr_ctrl     = wr & (reg_sel == REG_CTRL);

`ifdef SERV_WB_TIMER_MTIME64_EN
   assign wr_mtime_hi = wr & (reg_sel == REG_MTIME_HI);
   assign wr_cmp_hi   = wr & (reg_sel == REG_MTIMECMP_HI);
   assign mtime_lo    = mtime_q[31:0];
   assign mtime_hi    = mtime_q[63:32];
   assign cmp_lo      = mtimecmp_q[31:0];
   assign cmp_hi      = mtimecmp_q[63:32];
`else
   assign wr_mtime_hi = 1'b0;
   assign wr_cmp_hi   = 1'b0;
   assign mtime_lo    = mtime_q;
   assign mtime_hi    = '0;
   assign cmp_lo      = mtimecmp_q;
   assign cmp_hi      = '0;
`endif

   assign tick = en_q & (pre_q == div_q);

   // CTRL read image and its byte-lane-merged write image
   always_comb begin
      ctrl_rd                   = '0;
      ctrl_rd[0]                = en_q;
      ctrl_rd[8 +: PRESCALE_W]  = div_q;
      ctrl_new                  = merge_lanes(ctrl_rd, i_wb_dat, i_wb_sel);
   end

   // Low address bits and reserved CTRL bits carry no information.
   assign unused_bits = ^{i_wb_adr[1:0], ctrl_new};

   // Control register and prescaler next state
   always_comb begin
      en_d  = en_q;
      div_d = div_q;
      pre_d = pre_q;
      if (wr_ctrl) begin
         en_d  = ctrl_new[0];
         div_d = ctrl_new[8 +: PRESCALE_W];
         pre_d = '0;
      end else if (en_q) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
   end

   // mtime next state: a bus write to either half wins over a tick
   always_comb begin
      mtime_d = mtime_q;
      if (wr_mtime_lo || wr_mtime_hi) begin
`ifdef SERV_WB_TIMER_MTIME64_EN
         if (wr_mtime_lo) mtime_d[31:0]  = merge_lanes(mtime_q[31:0], i_wb_dat, i_wb_sel);
         if (wr_mtime_hi) mtime_d[63:32] = merge_lanes(mtime_q[63:32], i_wb_dat, i_wb_sel);
`else
         mtime_d = merge_lanes(mtime_q, i_wb_dat, i_wb_sel);
`endif
      end else if (tick) begin
         mtime_d = mtime_q + TIME_W'(1);
      end
   end

   // mtimecmp next state
   always_comb begin
      mtimecmp_d = mtimecmp_q;
`ifdef SERV_WB_TIMER_MTIME64_EN
      if (wr_cmp_lo) mtimecmp_d[31:0]  = merge_lanes(mtimecmp_q[31:0], i_wb_dat, i_wb_sel);
      if (wr_cmp_hi) mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], i_wb_dat, i_wb_sel);
`else
      if (wr_cmp_lo) mtimecmp_d = merge_lanes(mtimecmp_q, i_wb_dat, i_wb_sel);
`endif
   end

   // Read data mux; data is zero whenever no read is being acked
   always_comb begin
      rdt_d = '0;
      if (access && !i_wb_we) begin
         case (reg_sel)
            REG_MTIME_LO:    rdt_d = mtime_lo;
            REG_MTIME_HI:    rdt_d = mtime_hi;
            REG_MTIMECMP_LO: rdt_d = cmp_lo;
            REG_MTIMECMP_HI: rdt_d = cmp_hi;
            REG_CTRL:        rdt_d = ctrl_rd;
            default:         rdt_d = '0;
         endcase
      end
   end

   // Interrupt compares the current registers, so it lags them by one cycle
   always_comb begin
      irq_d = en_q & (mtime_q >= mtimecmp_q);
   end

   // State registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ack_q      <= 1'b0;
         rdt_q      <= '0;
         irq_q      <= 1'b0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         en_q       <= RESET_EN;
         div_q      <= '0;
         pre_q      <= '0;
      end else begin
         ack_q      <= i_wb_cyc & ~ack_q;
         rdt_q      <= rdt_d;
         irq_q      <= irq_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         en_q       <= en_d;
         div_q      <= div_d;
         pre_q      <= pre_d;
      end
   end

   assign o_wb_ack    = ack_q;
   assign o_wb_rdt    = rdt_q;
   assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_serv_wb_timer.sv
// Directed testbench for serv_wb_timer. Honours SERV_WB_TIMER_MTIME64_EN
// the same way the design does.

module tb_serv_wb_timer;

   localparam logic [4:0] A_MTIME_LO = 5'h00;
   localparam logic [4:0] A_MTIME_HI = 5'h04;
   localparam logic [4:0] A_CMP_LO   = 5'h08;
   localparam logic [4:0] A_CMP_HI   = 5'h0C;
   localparam logic [4:0] A_CTRL     = 5'h10;
   localparam logic [4:0] A_UNMAP    = 5'h14;

   logic        clk;
   logic        rst_n;
   logic [4:0]  adr;
   logic [31:0] dat;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic [31:0] rdt;
   logic        ack;
   logic        irq;

   int tests;
   int fails;

   serv_wb_timer #(
      .PRESCALE_W (8),
      .RESET_EN   (1'b0)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_wb_adr    (adr),
      .i_wb_dat    (dat),
      .i_wb_sel    (sel),
      .i_wb_we     (we),
      .i_wb_cyc    (cyc),
      .o_wb_rdt    (rdt),
      .o_wb_ack    (ack),
      .o_timer_irq (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One bus access, followed by one idle cycle. Returns 1 cycle after the ack edge.
   task automatic bus(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output logic [31:0] rd, output int lat);
      adr = a; dat = d; sel = s; we = w; cyc = 1'b1;
      lat = 0;
      rd  = '0;
      while (lat < 4) begin
         @(posedge clk);
         #1;
         lat++;
         if (ack) break;
      end
      if (!ack) begin
         tests++;
         fails++;
         $display("FAIL bus_timeout adr=%h: no ack within %0d cycles", a, lat);
      end
      rd  = rdt;
      cyc = 1'b0; we = 1'b0; sel = 4'h0;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] rd;
      int lat;
      bus(a, d, s, 1'b1, rd, lat);
   endtask

   task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
      int lat;
      bus(a, 32'h0, 4'h0, 1'b0, v, lat);
   endtask

   task automatic do_reset;
      rst_n = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      int lat;
      do_reset();
      tests++;
      if (ack !== 1'b0 || rdt !== 32'h0 || irq !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: ack=%b rdt=%h irq=%b, want 0/0/0", ack, rdt, irq);
      end
      bus(A_CTRL, 32'h0, 4'h0, 1'b0, v, lat);
      tests++;
      if (v !== 32'h0 || lat !== 1) begin
         fails++;
         $display("FAIL reset_ctrl: got %h lat %0d, want 00000000 lat 1", v, lat);
      end
      bus(A_MTIME_LO, 32'h0, 4'h0, 1'b0, v, lat);
      tests++;
      if (v !== 32'h0 || lat !== 1) begin
         fails++;
         $display("FAIL reset_mtime: got %h lat %0d, want 00000000 lat 1", v, lat);
      end
      bus(A_CMP_LO, 32'h0, 4'h0, 1'b0, v, lat);
      tests++;
      if (v !== 32'hFFFF_FFFF || lat !== 1) begin
         fails++;
         $display("FAIL reset_mtimecmp: got %h lat %0d, want ffffffff lat 1", v, lat);
      end
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL reset_irq: got %b, want 0", irq);
      end
   endtask

   task automatic test_irq;
      wr(A_CMP_LO, 32'h10, 4'hF);
      wr(A_MTIME_LO, 32'h0, 4'hF);
      // CTRL ack edge E0: mtime = k after edge E0+k, irq rises at E0+17.
      wr(A_CTRL, 32'h1, 4'hF);
      wait_cycles(15);
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL irq_early: got %b, want 0 while mtime=0x10 is being reached", irq);
      end
      wait_cycles(1);
      tests++;
      if (irq !== 1'b1) begin
         fails++;
         $display("FAIL irq_rise: got %b, want 1 the cycle after mtime=0x10", irq);
      end
      wr(A_CMP_LO, 32'h100, 4'hF);
      tests++;
      if (irq !== 1'b0) begin
         fails++;
         $display("FAIL irq_fall: got %b, want 0 after raising mtimecmp", irq);
      end
      wr(A_CTRL, 32'h0, 4'hF);
   endtask

   task automatic test_byte_lanes;
      logic [31:0] v;
      do_reset();
      wr(A_CMP_LO, 32'hAABB_CCDD, 4'b0010);
      rd_reg(A_CMP_LO, v);
      tests++;
      if (v !== 32'hFFFF_CCFF) begin
         fails++;
         $display("FAIL lane_merge: got %h, want ffffccff", v);
      end
      wr(A_CMP_LO, 32'h1234_5678, 4'b0000);
      rd_reg(A_CMP_LO, v);
      tests++;
      if (v !== 32'hFFFF_CCFF) begin
         fails++;
         $display("FAIL sel_zero: got %h, want ffffccff", v);
      end
      wr(A_CTRL, 32'hFFFF_FFFF, 4'b0001);
      wr(A_CTRL, 32'h0000_AB00, 4'b0010);
      rd_reg(A_CTRL, v);
      tests++;
      if (v !== 32'h0000_AB01) begin
         fails++;
         $display("FAIL ctrl_lanes: got %h, want 0000ab01", v);
      end
      wr(A_CTRL, 32'h0, 4'hF);
      wr(A_UNMAP, 32'hDEAD_BEEF, 4'hF);
      rd_reg(A_UNMAP, v);
      tests++;
      if (v !== 32'h0) begin
         fails++;
         $display("FAIL unmapped: got %h, want 00000000", v);
      end
   endtask

   task automatic test_prescaler;
      logic [31:0] v;
      do_reset();
      // Ack edge E0; ticks at E0+4k, the read samples mtime after E0+40.
      wr(A_CTRL, 32'h301, 4'hF);
      wait_cycles(39);
      rd_reg(A_MTIME_LO, v);
      tests++;
      if (v !== 32'd10) begin
         fails++;
         $display("FAIL prescale_div3: got %0d, want 10", v);
      end
      wr(A_CTRL, 32'h0, 4'hF);
   endtask

   task automatic test_write_wins;
      logic [31:0] v;
      do_reset();
      wr(A_CTRL, 32'h1, 4'hF);
      // Write lands on a tick edge (drops it), then two more ticks before EN clears.
      wr(A_MTIME_LO, 32'd5, 4'hF);
      wr(A_CTRL, 32'h0, 4'hF);
      rd_reg(A_MTIME_LO, v);
      tests++;
      if (v !== 32'd7) begin
         fails++;
         $display("FAIL write_wins: got %0d, want 7", v);
      end
   endtask

   task automatic test_wrap;
      logic [31:0] v;
      logic [31:0] exp_hi_wr, exp_hi, exp_cmp_hi;
`ifdef SERV_WB_TIMER_MTIME64_EN
      exp_hi_wr  = 32'h1234_5678;
      exp_hi     = 32'h1;
      exp_cmp_hi = 32'hFFFF_FFFF;
`else
      exp_hi_wr  = 32'h0;
      exp_hi     = 32'h0;
      exp_cmp_hi = 32'h0;
`endif
      do_reset();
      wr(A_MTIME_HI, 32'h1234_5678, 4'hF);
      rd_reg(A_MTIME_HI, v);
      tests++;
      if (v !== exp_hi_wr) begin
         fails++;
         $display("FAIL mtime_hi_write: got %h, want %h", v, exp_hi_wr);
      end
      wr(A_MTIME_HI, 32'h0, 4'hF);
      wr(A_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
      wr(A_CTRL, 32'h1, 4'hF);
      wr(A_CTRL, 32'h0, 4'hF);
      rd_reg(A_MTIME_LO, v);
      tests++;
      if (v !== 32'h0) begin
         fails++;
         $display("FAIL wrap_lo: got %h, want 00000000", v);
      end
      rd_reg(A_MTIME_HI, v);
      tests++;
      if (v !== exp_hi) begin
         fails++;
         $display("FAIL wrap_hi: got %h, want %h", v, exp_hi);
      end
      rd_reg(A_CMP_HI, v);
      tests++;
      if (v !== exp_cmp_hi) begin
         fails++;
         $display("FAIL cmp_hi: got %h, want %h", v, exp_cmp_hi);
      end
   endtask

   task automatic test_back_to_back;
      logic exp_ack;
      logic [31:0] exp_rdt;
      logic [31:0] v;
      do_reset();
      wr(A_CTRL, 32'h500, 4'hF);
      adr = A_CTRL; we = 1'b0; sel = 4'h0; cyc = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         exp_ack = (i % 2) == 1;
         exp_rdt = exp_ack ? 32'h500 : 32'h0;
         tests++;
         if (ack !== exp_ack || rdt !== exp_rdt) begin
            fails++;
            $display("FAIL b2b_cycle%0d: ack=%b rdt=%h, want ack=%b rdt=%h",
                     i, ack, rdt, exp_ack, exp_rdt);
         end
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (ack !== 1'b0 || rdt !== 32'h0) begin
         fails++;
         $display("FAIL async_reset: ack=%b rdt=%h, want 0/00000000", ack, rdt);
      end
      cyc = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      rd_reg(A_CTRL, v);
      tests++;
      if (v !== 32'h0) begin
         fails++;
         $display("FAIL ctrl_after_reset: got %h, want 00000000", v);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat = '0;
      test_reset();
      test_irq();
      test_byte_lanes();
      test_prescaler();
      test_write_wins();
      test_wrap();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
